g_and: RTL and testbench
========================

Name: g_and

Overview:
- Registered, parameterised bitwise AND gate. Operands a and b are ANDed bit by bit, and the result drives c.
- Used as the basic gate primitive in the logic-exercise designs and as a known-good reference for gate-level bring-up.
- Adds a valid pipeline, reduction status flags and a saturating count of rising edges on c.

Parameters:
- WIDTH, 1, operand and result width in bits (legal range 1..64).
- CNT_W, 8, width of the rising-edge counter on c[0].

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- in_valid  input  1  marks a and b as valid this cycle.
- c  output  WIDTH  registered a AND b.
- out_valid  output  1  c holds a result captured while in_valid was high.
- all_ones  output  1  registered AND-reduction of (a & b).
- any_one  output  1  registered OR-reduction of (a & b).
- rise_cnt  output  CNT_W  saturating count of 0->1 transitions of c[0].

Behaviour:
- Reset: One cycle with rst high at a rising clk edge is enough. rst is synchronous, active-high, and takes priority over all other inputs. At that edge:
  - c is cleared to 0.
  - out_valid, all_ones and any_one are cleared to 0.
  - rise_cnt is cleared to 0.
- Datapath update: every rising edge without rst, regardless of in_valid:
  - c <= a & b.
  - all_ones <= &(a & b).
  - any_one <= |(a & b).
- Valid pipeline: out_valid <= in_valid on each non-reset edge.
  - c is updated even when in_valid is low. Downstream logic qualifies c with out_valid.
- Latency: exactly 1 clock from the input sample to c and the flags. There is no combinational path from inputs to outputs.
- Truth table per bit (a,b -> c): 00->0, 01->0, 10->0, 11->1.
- Edge counter: rise_cnt increments by 1 on the edge where the new c[0] is 1 and the previous c[0] was 0.
  - It saturates at 2^CNT_W-1; it never wraps.
  - A reset mid-operation clears it.
  - The first edge after reset compares against the reset value c[0]=0.
- X handling: X or Z on inputs is not filtered and propagates as usual.
- With WIDTH=1, all_ones == any_one == c[0].

Test Plan:
- Reset check: assert rst for 2 cycles with a=1, b=1 -> c=0, out_valid=0, all_ones=0, any_one=0, rise_cnt=0. The cycle after rst falls, c=1.
- Exhaustive truth table (WIDTH=1): apply (a,b) = 00, 01, 10, 11, 00, each held for 100 ns (several clocks), in_valid=1 -> c = 0, 0, 0, 1, 0, each appearing one clock after the change. rise_cnt=1 at the end.
- Bitwise (WIDTH=4): a=4'b1100, b=4'b1010 -> c=4'b1000, all_ones=0, any_one=1. Then a=b=4'hF -> c=4'hF, all_ones=1.
- Valid pipeline: pulse in_valid for one cycle -> out_valid high for exactly one cycle, one clock later. c is still updated while in_valid is low.
- Counter saturation (CNT_W=2): toggle a between 0 and 1 with b=1, producing 5 rising edges on c[0] -> rise_cnt=3 and holds at 3.
- Mid-operation reset: assert rst while rise_cnt=2 and c=1 -> the next edge gives rise_cnt=0 and c=0. After release, with a=b=1, rise_cnt=1.

Source files
------------

// File: rtl/g_and.sv
// g_and: registered bitwise AND of two operands.
// Besides the result, it provides a one-cycle valid pipeline, AND/OR
// reduction flags of the result, and a saturating count of rising edges
// on c[0].
// Every output is a flop, so there is no combinational path from any
// input to any output.
module g_and #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] c,
    output logic             out_valid,
    output logic             all_ones,
    output logic             any_one,
    output logic [CNT_W-1:0] rise_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] ab;
    logic             rise;

    assign ab = a & b;

    // A rising edge is seen when the value about to load into c[0] is 1
    // and the value currently held in c[0] is 0. After reset, c[0] holds
    // 0, so the first edge out of reset is compared against that cleared
    // value.
    assign rise = ab[0] & ~c[0];

    // Result and status flags load on every edge. c is not gated by
    // in_valid; downstream logic uses out_valid to qualify it.
    always_ff @(posedge clk) begin
        if (rst) begin
            c         <= '0;
            out_valid <= 1'b0;
            all_ones  <= 1'b0;
            any_one   <= 1'b0;
        end else begin
            c         <= ab;
            out_valid <= in_valid;
            all_ones  <= &ab;
            any_one   <= |ab;
        end
    end

    // The rising-edge counter stops at its maximum value instead of
    // wrapping to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_cnt <= '0;
        end else if (rise && (rise_cnt != CNT_MAX)) begin
            rise_cnt <= rise_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_g_and.sv
// Testbench for g_and. It runs two instances on the same stimulus: a
// 4-bit instance with a 2-bit counter, and a 1-bit instance whose
// operands are bit 0 of the 4-bit operands. Each stimulus step pushes the
// expected response onto a queue, and a monitor process pops and compares
// one entry after every clock edge. Fixed values are also checked at
// chosen points in the sequence.
module tb_g_and;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       in_valid;

    logic [3:0] c4;
    logic       ov4;
    logic       all4;
    logic       any4;
    logic [1:0] cnt4;

    logic       c1;
    logic       ov1;
    logic       all1;
    logic       any1;
    logic [7:0] cnt1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] c4;
        logic       v;
        logic       all4;
        logic       any4;
        logic [1:0] cnt4;
        logic       c1;
        logic [7:0] cnt1;
    } exp_t;

    exp_t sb[$];

    // Reference state used to build the expected responses.
    logic m_c0  = 1'b0;
    int   m_cnt = 0;

    always #5 clk = ~clk;

    g_and #(.WIDTH(4), .CNT_W(2)) dut4 (
        .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid),
        .c(c4), .out_valid(ov4), .all_ones(all4), .any_one(any4),
        .rise_cnt(cnt4)
    );

    g_and #(.WIDTH(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .a(a[0:0]), .b(b[0:0]), .in_valid(in_valid),
        .c(c1), .out_valid(ov1), .all_ones(all1), .any_one(any1),
        .rise_cnt(cnt1)
    );

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, got, exp, $time);
        end
    endtask

    // Drive one input set for n cycles. Each cycle pushes the response
    // expected after the next rising edge.
    task automatic step(input logic r, input logic [3:0] va,
                        input logic [3:0] vb, input logic v, input int n);
        exp_t e;
        logic [3:0] p;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = r; a = va; b = vb; in_valid = v;
            if (r) begin
                p     = 4'h0;
                m_cnt = 0;
                e.v   = 1'b0;
            end else begin
                p   = va & vb;
                e.v = v;
                if (p[0] && !m_c0) m_cnt++;
            end
            m_c0   = p[0];
            e.c4   = p;
            e.all4 = (p == 4'hF);
            e.any4 = (p != 4'h0);
            e.cnt4 = (m_cnt > 3)   ? 2'd3   : 2'(m_cnt);
            e.c1   = p[0];
            e.cnt1 = (m_cnt > 255) ? 8'd255 : 8'(m_cnt);
            sb.push_back(e);
        end
    endtask

    // Compare the outputs from the most recent edge with fixed values.
    task automatic hand(input string name, input logic [63:0] got,
                        input logic [63:0] exp);
        check(name, got, exp);
    endtask

    // Monitor: after every edge, compare both instances against the
    // oldest expected response in the queue.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("c4",        c4,   e.c4);
            check("out_valid4", ov4, e.v);
            check("all_ones4", all4, e.all4);
            check("any_one4",  any4, e.any4);
            check("rise_cnt4", cnt4, e.cnt4);
            check("c1",        c1,   e.c1);
            check("out_valid1", ov1, e.v);
            check("all_ones1", all1, e.c1);
            check("any_one1",  any1, e.c1);
            check("rise_cnt1", cnt1, e.cnt1);
        end
    end

    initial begin
        rst = 1'b1; a = 4'hF; b = 4'hF; in_valid = 1'b1;

        // Reset held for two cycles with both operands all ones.
        step(1'b1, 4'hF, 4'hF, 1'b1, 2);
        @(posedge clk); #1;
        hand("rst_c", c4, 4'h0);
        hand("rst_cnt", cnt4, 2'd0);
        step(1'b0, 4'hF, 4'hF, 1'b1, 1);
        @(posedge clk); #1;
        hand("post_rst_c", c4, 4'hF);

        // Truth table on bit 0, each input pair held for 10 cycles.
        step(1'b1, 4'h0, 4'h0, 1'b0, 1);
        step(1'b0, 4'h0, 4'h0, 1'b1, 10);
        step(1'b0, 4'h0, 4'h1, 1'b1, 10);
        step(1'b0, 4'h1, 4'h0, 1'b1, 10);
        step(1'b0, 4'h1, 4'h1, 1'b1, 10);
        step(1'b0, 4'h0, 4'h0, 1'b1, 10);
        @(posedge clk); #1;
        hand("tt_c1", c1, 1'b0);
        hand("tt_cnt1", cnt1, 8'd1);

        // Bitwise AND and the reduction flags.
        step(1'b0, 4'b1100, 4'b1010, 1'b1, 3);
        @(posedge clk); #1;
        hand("bw_c", c4, 4'b1000);
        hand("bw_all", all4, 1'b0);
        hand("bw_any", any4, 1'b1);
        step(1'b0, 4'hF, 4'hF, 1'b1, 3);
        @(posedge clk); #1;
        hand("ff_c", c4, 4'hF);
        hand("ff_all", all4, 1'b1);

        // A one-cycle in_valid pulse. c keeps updating while in_valid
        // is low.
        step(1'b0, 4'h3, 4'h1, 1'b0, 3);
        @(posedge clk); #1;
        hand("nv_c", c4, 4'h1);
        hand("nv_ov", ov4, 1'b0);
        step(1'b0, 4'h6, 4'h7, 1'b1, 1);
        step(1'b0, 4'h6, 4'h7, 1'b0, 3);

        // Counter saturation: five rising edges on c[0].
        step(1'b1, 4'h0, 4'h1, 1'b0, 1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'h0, 4'h1, 1'b1, 1);
            step(1'b0, 4'h1, 4'h1, 1'b1, 1);
        end
        @(posedge clk); #1;
        hand("sat_cnt4", cnt4, 2'd3);
        hand("sat_cnt1", cnt1, 8'd5);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 4'h0, 4'h1, 1'b1, 1);
            step(1'b0, 4'h1, 4'h1, 1'b1, 1);
        end
        @(posedge clk); #1;
        hand("hold_cnt4", cnt4, 2'd3);
        hand("hold_cnt1", cnt1, 8'd7);

        // Reset in mid-operation, while rise_cnt is 2 and c[0] is 1.
        step(1'b1, 4'h0, 4'h1, 1'b1, 1);
        step(1'b0, 4'h1, 4'h1, 1'b1, 1);
        step(1'b0, 4'h0, 4'h1, 1'b1, 1);
        step(1'b0, 4'h1, 4'h1, 1'b1, 1);
        @(posedge clk); #1;
        hand("mid_pre_cnt", cnt4, 2'd2);
        hand("mid_pre_c", c4, 4'h1);
        step(1'b1, 4'hF, 4'hF, 1'b1, 1);
        @(posedge clk); #1;
        hand("mid_rst_cnt", cnt4, 2'd0);
        hand("mid_rst_c", c4, 4'h0);
        step(1'b0, 4'hF, 4'hF, 1'b1, 1);
        @(posedge clk); #1;
        hand("mid_post_cnt", cnt4, 2'd1);

        // Give the monitor a bounded number of cycles to empty the queue.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog: stops the run if the stimulus sequence never completes.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
